// File: rtl/acc_dump_pkg.sv
// Shared definitions for the integrate-and-dump accumulator and the scaling
// stage that follows it: sample-type names, output width rule, FSM encoding.
package acc_dump_pkg;

    localparam string DT_SIGNED   = "signed";
    localparam string DT_UNSIGNED = "unsigned";

    typedef enum logic {
        IDLE,
        ACC
    } state_e;

    // One extra bit per doubling of frame length keeps a full-length frame from overflowing.
    function automatic int dout_width(input int din_width, input int acc_len_bits);
        return din_width + acc_len_bits;
    endfunction

endpackage

// File: rtl/acc_dump_ctrl.sv
// Frame controller: tracks position within a frame, latches the frame length
// and tells the datapath whether to load, add, dump or clear the accumulator.
module acc_ctrl
    import acc_dump_pkg::*;
#(
    parameter int ACC_LEN_BITS = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ACC_LEN_BITS-1:0] acc_len_i,
    input  logic                    din_valid_i,
    input  logic                    sync_i,
    output logic                    load_o,
    output logic                    add_o,
    output logic                    dump_o,
    output logic                    clear_o,
    output logic                    resync_err_o
);

    state_e                  state_q, state_d;
    logic [ACC_LEN_BITS-1:0] cnt_q, cnt_d;
    logic [ACC_LEN_BITS-1:0] len_q, len_d;
    logic                    resync_q, resync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            resync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            resync_q <= resync_d;
        end
    end

    // cnt holds the number of samples already folded into the current frame.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        resync_d = 1'b0;
        load_o   = 1'b0;
        add_o    = 1'b0;
        dump_o   = 1'b0;
        clear_o  = 1'b0;
        if (din_valid_i) begin
            case (state_q)
                IDLE: begin
                    if (sync_i) begin
                        state_d = ACC;
                        len_d   = acc_len_i;
                        if (acc_len_i == '0) begin
                            dump_o = 1'b1;
                            cnt_d  = '0;
                        end else begin
                            load_o = 1'b1;
                            cnt_d  = {{(ACC_LEN_BITS-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ACC: begin
                    if (sync_i && cnt_q != '0) begin
                        // A sync with a one-sample frame length cannot also dump, so that sample is dropped.
                        resync_d = 1'b1;
                        len_d    = acc_len_i;
                        if (acc_len_i == '0) begin
                            clear_o = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            load_o = 1'b1;
                            cnt_d  = {{(ACC_LEN_BITS-1){1'b0}}, 1'b1};
                        end
                    end else if (cnt_q == len_q) begin
                        dump_o = 1'b1;
                        cnt_d  = '0;
                        len_d  = acc_len_i;
                    end else begin
                        add_o = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign resync_err_o = resync_q;

endmodule

// File: rtl/acc_dump.sv
// Integrate-and-dump accumulator: sums acc_len+1 samples per frame and emits
// one full-precision registered result per frame.
module acc_dump
    import acc_dump_pkg::*;
#(
    parameter int    DIN_WIDTH    = 16,
    parameter string DATA_TYPE    = "signed",
    parameter int    ACC_LEN_BITS = 10,
    parameter int    DOUT_WIDTH   = dout_width(DIN_WIDTH, ACC_LEN_BITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ACC_LEN_BITS-1:0] acc_len,
    input  logic [DIN_WIDTH-1:0]    din,
    input  logic                    din_valid,
    input  logic                    sync,
    output logic [DOUT_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    resync_err,
    output logic [31:0]             frame_cnt
);

    logic                  load, add, dump, clear;
    logic [DOUT_WIDTH-1:0] din_ext, sum;
    logic [DOUT_WIDTH-1:0] acc_q, acc_d;
    logic [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q;
    logic [31:0]           frame_cnt_q;

    acc_ctrl #(
        .ACC_LEN_BITS(ACC_LEN_BITS)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .acc_len_i   (acc_len),
        .din_valid_i (din_valid),
        .sync_i      (sync),
        .load_o      (load),
        .add_o       (add),
        .dump_o      (dump),
        .clear_o     (clear),
        .resync_err_o(resync_err)
    );

    generate
        if (DATA_TYPE == DT_SIGNED) begin : g_sext
            assign din_ext = {{(DOUT_WIDTH-DIN_WIDTH){din[DIN_WIDTH-1]}}, din};
        end else begin : g_zext
            assign din_ext = {{(DOUT_WIDTH-DIN_WIDTH){1'b0}}, din};
        end
    endgenerate

    // acc is zero whenever a dump can start a frame, so the dump sum needs no separate base select.
    always_comb begin
        sum    = acc_q + din_ext;
        acc_d  = acc_q;
        dout_d = dout_q;
        if (dump) begin
            dout_d = sum;
            acc_d  = '0;
        end else if (load) begin
            acc_d = din_ext;
        end else if (add) begin
            acc_d = sum;
        end else if (clear) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            acc_q        <= acc_d;
            dout_q       <= dout_d;
            dout_valid_q <= dump;
            if (dump) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_acc_dump.sv
// Directed self-checking bench for acc_dump: a signed and an unsigned instance
// share one stimulus stream; expected values are hand-computed constants.
module tb_acc_dump;

    logic        clk;
    logic        rst_n;
    logic [9:0]  acc_len;
    logic [15:0] din;
    logic        din_valid;
    logic        sync;

    logic [25:0] doutS, doutU;
    logic        doutValidS, doutValidU;
    logic        resyncErrS, resyncErrU;
    logic [31:0] frameCntS, frameCntU;

    int nCompared;
    int nMismatched;

    acc_dump #(.DIN_WIDTH(16), .DATA_TYPE("signed"), .ACC_LEN_BITS(10)) dutS (
        .clk(clk), .rst_n(rst_n), .acc_len(acc_len), .din(din),
        .din_valid(din_valid), .sync(sync), .dout(doutS),
        .dout_valid(doutValidS), .resync_err(resyncErrS), .frame_cnt(frameCntS)
    );

    acc_dump #(.DIN_WIDTH(16), .DATA_TYPE("unsigned"), .ACC_LEN_BITS(10)) dutU (
        .clk(clk), .rst_n(rst_n), .acc_len(acc_len), .din(din),
        .din_valid(din_valid), .sync(sync), .dout(doutU),
        .dout_valid(doutValidU), .resync_err(resyncErrU), .frame_cnt(frameCntU)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncates a signed integer to the 26-bit dout width, zero-padded to 64 bits.
    function automatic logic [63:0] d26(input int v);
        logic [25:0] t;
        t = v[25:0];
        return {38'b0, t};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one cycle of input, then returns 1 ns after the capturing edge.
    task automatic applyStimulus(input bit v, input bit s, input int d);
        din_valid = v;
        sync      = s;
        din       = d[15:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int firstPulse;
        int secondPulse;
        int dataS[4];
        nCompared   = 0;
        nMismatched = 0;
        rst_n       = 1'b0;
        din_valid   = 1'b0;
        sync        = 1'b0;
        din         = '0;
        acc_len     = 10'd3;

        #12;
        checkOutput("reset dout", 64'(doutS), 64'd0);
        checkOutput("reset dout_valid", 64'(doutValidS), 64'd0);
        checkOutput("reset resync_err", 64'(resyncErrS), 64'd0);
        checkOutput("reset frame_cnt", 64'(frameCntS), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] signed frame of four samples");
        dataS[0] = 5; dataS[1] = -2; dataS[2] = 7; dataS[3] = 1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, i == 0, dataS[i]);
            if (i < 3) checkOutput("t1 no early valid", 64'(doutValidS), 64'd0);
        end
        checkOutput("t1 dout", 64'(doutS), d26(11));
        checkOutput("t1 dout_valid", 64'(doutValidS), 64'd1);
        checkOutput("t1 frame_cnt", 64'(frameCntS), 64'd1);
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("t1 valid one cycle", 64'(doutValidS), 64'd0);
        checkOutput("t1 dout held", 64'(doutS), d26(11));

        $display("[TB] acc_len change mid-frame");
        applyStimulus(1'b1, 1'b0, 10);
        acc_len = 10'd1;
        applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b1, 1'b0, 30);
        checkOutput("t5 still running", 64'(doutValidS), 64'd0);
        applyStimulus(1'b1, 1'b0, 40);
        checkOutput("t5 old length dout", 64'(doutS), d26(100));
        checkOutput("t5 old length valid", 64'(doutValidS), 64'd1);
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("t5 new length mid", 64'(doutValidS), 64'd0);
        applyStimulus(1'b1, 1'b0, 4);
        checkOutput("t5 new length dout", 64'(doutS), d26(7));
        checkOutput("t5 new length valid", 64'(doutValidS), 64'd1);
        applyStimulus(1'b1, 1'b0, 6);
        acc_len = 10'd3;
        applyStimulus(1'b1, 1'b0, -8);
        checkOutput("t5 back-to-back dout", 64'(doutS), d26(-2));
        checkOutput("t5 frame_cnt", 64'(frameCntS), 64'd4);

        $display("[TB] resync on third sample");
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("t4 sync at frame start", 64'(resyncErrS), 64'd0);
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b1, 1'b1, 100);
        checkOutput("t4 resync_err", 64'(resyncErrS), 64'd1);
        checkOutput("t4 no dout_valid", 64'(doutValidS), 64'd0);
        applyStimulus(1'b1, 1'b0, 200);
        checkOutput("t4 resync one cycle", 64'(resyncErrS), 64'd0);
        applyStimulus(1'b1, 1'b0, 300);
        applyStimulus(1'b1, 1'b0, 400);
        checkOutput("t4 new frame dout", 64'(doutS), d26(1000));
        checkOutput("t4 new frame valid", 64'(doutValidS), 64'd1);

        $display("[TB] resync on last sample");
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 4);
        checkOutput("t4b resync wins", 64'(resyncErrS), 64'd1);
        checkOutput("t4b no dout_valid", 64'(doutValidS), 64'd0);
        checkOutput("t4b dout held", 64'(doutS), d26(1000));
        applyStimulus(1'b1, 1'b0, 5);
        applyStimulus(1'b1, 1'b0, 6);
        applyStimulus(1'b1, 1'b0, 7);
        checkOutput("t4b dout", 64'(doutS), d26(22));
        checkOutput("t4b frame_cnt", 64'(frameCntS), 64'd6);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 1'b0, 9);
        applyStimulus(1'b1, 1'b0, 9);
        rst_n = 1'b0;
        #1;
        checkOutput("t6 dout cleared", 64'(doutS), 64'd0);
        checkOutput("t6 frame_cnt cleared", 64'(frameCntS), 64'd0);
        #2;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 9);
            if (doutValidS) pulses++;
        end
        checkOutput("t6 ignored without sync", 64'(pulses), 64'd0);
        checkOutput("t6 dout still zero", 64'(doutS), 64'd0);

        $display("[TB] gapped input, eight-sample frame");
        acc_len = 10'd7;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, i == 1, i);
            if (i < 8) begin
                checkOutput("t3 no early valid", 64'(doutValidS), 64'd0);
                applyStimulus(1'b0, 1'b0, 1000);
            end
        end
        checkOutput("t3 dout", 64'(doutS), d26(36));
        checkOutput("t3 dout_valid", 64'(doutValidS), 64'd1);
        checkOutput("t3 frame_cnt", 64'(frameCntS), 64'd1);

        $display("[TB] unsigned full-length frames");
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        acc_len     = 10'd1023;
        pulses      = 0;
        firstPulse  = -1;
        secondPulse = -1;
        for (int i = 0; i < 2048; i++) begin
            applyStimulus(1'b1, i == 0, 32'hFFFF);
            if (doutValidU) begin
                pulses++;
                if (pulses == 1) firstPulse = i;
                if (pulses == 2) secondPulse = i;
                checkOutput("t2 dout", 64'(doutU), 64'h3FFFC00);
            end
        end
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("t2 pulse count", 64'(pulses), 64'd2);
        checkOutput("t2 first pulse", 64'(firstPulse), 64'd1023);
        checkOutput("t2 pulse spacing", 64'(secondPulse - firstPulse), 64'd1024);
        checkOutput("t2 frame_cnt", 64'(frameCntU), 64'd2);
        checkOutput("t2 signed view", 64'(doutS), d26(-1024));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
